encoder_serializer: RTL and testbench
=====================================

// Module: encoder_serializer
// PURPOSE
//  Inverse of the team's 4-to-16 decoder: takes a 16-bit multi-hot vector and
//  emits the 4-bit index of every set bit, one per output handshake.
//  Emission order is ascending, lowest set bit first.
//  Sits between a request/flag bank and any consumer that needs binary indices.
// PARAMETERS
//  WIDTH  16  input vector width; power of two, >= 2
//  IDX_W  4   index width, $clog2(WIDTH); derived, do not override
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      in_vec valid
//  in_ready   out  1      block can accept a vector
//  in_vec     in   WIDTH  multi-hot vector to encode
//  out_valid  out  1      out_idx/out_last/out_none valid
//  out_ready  in   1      consumer accepts current beat
//  out_idx    out  IDX_W  index of lowest pending set bit
//  out_last   out  1      this beat is final for the accepted vector
//  out_none   out  1      accepted vector was all-zero (out_idx=0, out_last=1)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, pending=0, in_ready=1, out_valid=0,
//    out_idx=0, out_last=0, out_none=0. Held while rst_n low.
//  - FSM: IDLE, EMIT. in_ready = (state==IDLE); out_valid = (state==EMIT).
//  - IDLE: in_valid&&in_ready -> pending<=in_vec, zero_flag<=(in_vec==0),
//    state<=EMIT. First out_valid the cycle after acceptance (latency 1).
//  - EMIT: out_idx = priority encode of lowest set bit of pending (0 if
//    pending==0); out_last = zero_flag or popcount(pending)==1;
//    out_none = zero_flag.
//  - out_valid&&out_ready in EMIT: clear bit out_idx in pending; if out_last,
//    state<=IDLE, clear zero_flag; else stay in EMIT (next index on next cycle).
//  - Backpressure: out_valid && !out_ready -> all out_* held stable, pending
//    unchanged. out_valid never drops without a handshake except on reset.
//  - in_valid in EMIT is ignored; no capture, no error. Producer must hold.
//  - Vector with N set bits: N beats; all-zero vector: exactly 1 beat with
//    out_none=1. Min period between acceptances = N+1 cycles (no overlap of
//    last beat and next acceptance).
//  - Bit WIDTH-1 is emitted last; index never wraps; no beat for a cleared bit.
//  - out_* are functions of registered state only; no comb path from
//    in_* or out_ready to any output.
//  - Reset mid-operation discards pending bits; no further beats for them.
// TESTING
//  1. in_vec=16'h0001, out_ready=1 -> 1 cycle later one beat idx=0,last=1,
//     none=0; next cycle in_ready=1.
//  2. in_vec=16'h8421, out_ready=1 -> idx 0,5,10,15 on 4 consecutive cycles,
//     last=1 only on 15; then IDLE.
//  3. in_vec=16'h0000 -> single beat idx=0,none=1,last=1; then in_ready=1.
//  4. in_vec=16'h0006, out_ready=0 for 3 cycles -> idx=1,last=0 held stable
//     3 cycles; then out_ready=1 -> idx 1, then idx 2 with last=1.
//  5. in_vec=16'hFFFF, after 3 beats (idx 0,1,2) drop rst_n mid-cycle ->
//     out_valid=0 immediately; after release in_ready=1; no further beats.
//  6. Accept 16'h0003, pulse in_valid with 16'h0100 during EMIT -> only idx 0,1
//     emitted; 16'h0100 re-held in IDLE -> accepted, idx=8,last=1.

Source files
------------

// File: rtl/encoder_serializer.sv
// Serialises a multi-hot vector into the binary indices of its set bits,
// lowest bit first, one index per output handshake.
module encoder_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] low_idx;
  logic             single_bit;
  logic             emit;

  // Scan high to low so the lowest set bit wins the final assignment.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  assign single_bit = (pending_q != '0) &&
                      ((pending_q & (pending_q - WIDTH'(1))) == '0);

  assign emit = (state_q == StEmit);

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = emit;
    out_idx   = emit ? low_idx : '0;
    out_none  = emit & zero_q;
    out_last  = emit & (zero_q | single_bit);
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pending_d = in_vec;
          zero_d    = (in_vec == '0);
          state_d   = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          pending_d = pending_q & ~(WIDTH'(1) << low_idx);
          if (out_last) begin
            state_d = StIdle;
            zero_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_encoder_serializer.sv
// Directed bench for encoder_serializer: stimulus pushes expected beats to a
// scoreboard queue, a negedge monitor pops and compares on every handshake.
module tb_encoder_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_none;

  int checks;
  int errors;

  // Expected beat packed as {idx, last, none}.
  logic [5:0] sb[$];

  encoder_serializer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [3:0] idx, input logic last, input logic none);
    sb.push_back({idx, last, none});
  endtask

  // Monitor: handshake completes on the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got idx=%0d last=%0b none=%0b expected no beat",
                 out_idx, out_last, out_none);
      end else begin
        logic [5:0] e;
        e = sb.pop_front();
        if ({out_idx, out_last, out_none} !== e) begin
          errors++;
          $display("FAIL beat: got idx=%0d last=%0b none=%0b expected idx=%0d last=%0b none=%0b",
                   out_idx, out_last, out_none, e[5:2], e[1], e[0]);
        end
      end
    end
  end

  // Present a vector and hold it until accepted; returns 1ns after acceptance edge.
  task automatic send(input logic [15:0] v);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_vec   = v;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance of %h", v);
    end
  endtask

  // Wait for scoreboard empty and block back in IDLE.
  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (sb.size() == 0) && in_ready;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_outs", {27'd0, out_idx, out_last, out_none}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single bit 0
    expect_beat(4'd0, 1'b1, 1'b0);
    send(16'h0001);
    check("t1_latency", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    check("t1_sb_empty", sb.size(), 32'd0);

    // 2: four spaced bits on consecutive cycles
    expect_beat(4'd0, 1'b0, 1'b0);
    expect_beat(4'd5, 1'b0, 1'b0);
    expect_beat(4'd10, 1'b0, 1'b0);
    expect_beat(4'd15, 1'b1, 1'b0);
    send(16'h8421);
    repeat (3) @(posedge clk);
    #1;
    check("t2_busy", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("t2_idle", {31'd0, in_ready}, 32'd1);
    check("t2_sb_empty", sb.size(), 32'd0);

    // 3: all-zero vector
    expect_beat(4'd0, 1'b1, 1'b1);
    send(16'h0000);
    @(posedge clk);
    #1;
    check("t3_idle", {31'd0, in_ready}, 32'd1);

    // 4: backpressure holds outputs
    out_ready = 1'b0;
    expect_beat(4'd1, 1'b0, 1'b0);
    expect_beat(4'd2, 1'b1, 1'b0);
    send(16'h0006);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold", {26'd0, out_valid, out_idx, out_last, out_none}, {26'd0, 1'b1, 4'd1, 2'b00});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t4_idle", {31'd0, in_ready}, 32'd1);
    check("t4_sb_empty", sb.size(), 32'd0);

    // 5: reset mid-operation discards pending bits
    expect_beat(4'd0, 1'b0, 1'b0);
    expect_beat(4'd1, 1'b0, 1'b0);
    expect_beat(4'd2, 1'b0, 1'b0);
    send(16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("t5_after_rst", {30'd0, in_ready, out_valid}, 32'd2);
    end
    check("t5_sb_empty", sb.size(), 32'd0);

    // 6: in_valid during EMIT ignored, re-held vector accepted later
    expect_beat(4'd0, 1'b0, 1'b0);
    expect_beat(4'd1, 1'b1, 1'b0);
    send(16'h0003);
    check("t6_busy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_vec   = 16'h0100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("t6_drain_a");
    expect_beat(4'd8, 1'b1, 1'b0);
    send(16'h0100);
    drain("t6_drain_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
